// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hazard_scoreboard                                         |
// | Brief    : RAW hazard tracker; selects forward sources, stalls on    |
// |            load-use, counts stall cycles.                            |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int PIPE_DEPTH = 3,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16
) (
  input  logic                            clk,
  input  logic                            resetIn,
  input  logic                            issueValid,
  input  logic [REG_ADDR_W-1:0]           issueRd,
  input  logic                            issueWe,
  input  logic                            issueIsLoad,
  input  logic [REG_ADDR_W-1:0]           rs1,
  input  logic [REG_ADDR_W-1:0]           rs2,
  input  logic                            useRs1,
  input  logic                            useRs2,
  input  logic                            flushIn,
  output logic                            stall,
  output logic                            issueAccept,
  output logic [$clog2(PIPE_DEPTH+1)-1:0] fwdSel1,
  output logic [$clog2(PIPE_DEPTH+1)-1:0] fwdSel2,
  output logic [CNT_W-1:0]                stallCount
);

  localparam int c_selW = $clog2(PIPE_DEPTH + 1);

  logic [PIPE_DEPTH:1]   r_valid;
  logic [PIPE_DEPTH:1]   r_we;
  logic [PIPE_DEPTH:1]   r_isLoad;
  logic [REG_ADDR_W-1:0] r_rd [1:PIPE_DEPTH];
  logic [CNT_W-1:0]      r_stallCount;

  logic [PIPE_DEPTH:1]   w_match1;
  logic [PIPE_DEPTH:1]   w_match2;
  logic [c_selW-1:0]     w_sel1;
  logic [c_selW-1:0]     w_sel2;
  logic                  w_loadHaz1;
  logic                  w_loadHaz2;
  logic                  w_stall;
  logic                  w_accept;

  generate
    for (genvar k = 1; k <= PIPE_DEPTH; k++) begin : g_match
      assign w_match1[k] = useRs1 && (rs1 != '0) && r_valid[k] && r_we[k] && (r_rd[k] == rs1);
      assign w_match2[k] = useRs2 && (rs2 != '0) && r_valid[k] && r_we[k] && (r_rd[k] == rs2);
    end
  endgenerate

  // Scan oldest to youngest so the youngest matching stage is the one kept.
  always_comb begin
    w_sel1     = '0;
    w_sel2     = '0;
    w_loadHaz1 = 1'b0;
    w_loadHaz2 = 1'b0;
    for (int k = PIPE_DEPTH; k >= 1; k--) begin
      if (w_match1[k]) begin
        w_sel1     = c_selW'(k);
        w_loadHaz1 = r_isLoad[k] && (k < LOAD_STAGE);
      end
      if (w_match2[k]) begin
        w_sel2     = c_selW'(k);
        w_loadHaz2 = r_isLoad[k] && (k < LOAD_STAGE);
      end
    end
  end

  assign w_stall  = !resetIn && issueValid && (w_loadHaz1 || w_loadHaz2) && !flushIn;
  assign w_accept = !resetIn && issueValid && !w_stall && !flushIn;

  assign stall       = w_stall;
  assign issueAccept = w_accept;
  assign fwdSel1     = resetIn ? '0 : w_sel1;
  assign fwdSel2     = resetIn ? '0 : w_sel2;
  assign stallCount  = r_stallCount;

  // Stalled or flushed issue slots become bubbles in S1; older stages keep moving.
  always_ff @(posedge clk or posedge resetIn) begin
    if (resetIn) begin
      r_valid  <= '0;
      r_we     <= '0;
      r_isLoad <= '0;
      for (int k = 1; k <= PIPE_DEPTH; k++) r_rd[k] <= '0;
    end else begin
      r_valid[1]  <= w_accept;
      r_we[1]     <= issueWe;
      r_isLoad[1] <= issueIsLoad;
      r_rd[1]     <= issueRd;
      for (int k = 2; k <= PIPE_DEPTH; k++) begin
        r_valid[k]  <= r_valid[k-1];
        r_we[k]     <= r_we[k-1];
        r_isLoad[k] <= r_isLoad[k-1];
        r_rd[k]     <= r_rd[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge resetIn) begin
    if (resetIn) begin
      r_stallCount <= '0;
    end else if (w_stall && (r_stallCount != '1)) begin
      r_stallCount <= r_stallCount + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_hazard_scoreboard                                      |
// | Brief    : Directed-vector bench for hazard_scoreboard (default and  |
// |            2-bit stall counter instances share stimulus).            |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_hazard_scoreboard;

  localparam int REG_ADDR_W = 5;
  localparam int PIPE_DEPTH = 3;
  localparam int LOAD_STAGE = 2;
  localparam int SEL_W      = $clog2(PIPE_DEPTH + 1);

  logic                  clk = 1'b0;
  logic                  resetIn;
  logic                  issueValid;
  logic [REG_ADDR_W-1:0] issueRd;
  logic                  issueWe;
  logic                  issueIsLoad;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic                  useRs1;
  logic                  useRs2;
  logic                  flushIn;

  logic                  stall;
  logic                  issueAccept;
  logic [SEL_W-1:0]      fwdSel1;
  logic [SEL_W-1:0]      fwdSel2;
  logic [15:0]           stallCount;

  logic                  stallSat;
  logic                  acceptSat;
  logic [SEL_W-1:0]      sel1Sat;
  logic [SEL_W-1:0]      sel2Sat;
  logic [1:0]            countSat;

  int nVectors     = 0;
  int nMiscompares = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .REG_ADDR_W(REG_ADDR_W), .PIPE_DEPTH(PIPE_DEPTH), .LOAD_STAGE(LOAD_STAGE), .CNT_W(16)
  ) dut (
    .clk(clk), .resetIn(resetIn), .issueValid(issueValid), .issueRd(issueRd),
    .issueWe(issueWe), .issueIsLoad(issueIsLoad), .rs1(rs1), .rs2(rs2),
    .useRs1(useRs1), .useRs2(useRs2), .flushIn(flushIn), .stall(stall),
    .issueAccept(issueAccept), .fwdSel1(fwdSel1), .fwdSel2(fwdSel2),
    .stallCount(stallCount)
  );

  hazard_scoreboard #(
    .REG_ADDR_W(REG_ADDR_W), .PIPE_DEPTH(PIPE_DEPTH), .LOAD_STAGE(LOAD_STAGE), .CNT_W(2)
  ) dutSat (
    .clk(clk), .resetIn(resetIn), .issueValid(issueValid), .issueRd(issueRd),
    .issueWe(issueWe), .issueIsLoad(issueIsLoad), .rs1(rs1), .rs2(rs2),
    .useRs1(useRs1), .useRs2(useRs2), .flushIn(flushIn), .stall(stallSat),
    .issueAccept(acceptSat), .fwdSel1(sel1Sat), .fwdSel2(sel2Sat),
    .stallCount(countSat)
  );

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nVectors++;
    if (observed !== expected) begin
      nMiscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic setIn(input logic v, input logic [REG_ADDR_W-1:0] rd, input logic we,
                       input logic ld, input logic [REG_ADDR_W-1:0] a,
                       input logic [REG_ADDR_W-1:0] b, input logic u1, input logic u2,
                       input logic fl);
    @(negedge clk);
    issueValid  = v;
    issueRd     = rd;
    issueWe     = we;
    issueIsLoad = ld;
    rs1         = a;
    rs2         = b;
    useRs1      = u1;
    useRs2      = u2;
    flushIn     = fl;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) setIn(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset with a would-be hazard presented: everything must read zero.
    resetIn = 1'b1;
    issueValid = 1'b1; issueRd = 5'd5; issueWe = 1'b1; issueIsLoad = 1'b1;
    rs1 = 5'd5; rs2 = 5'd5; useRs1 = 1'b1; useRs2 = 1'b1; flushIn = 1'b0;
    #1;
    checkVal("rst_stall",  stall, 0);
    checkVal("rst_accept", issueAccept, 0);
    checkVal("rst_sel1",   fwdSel1, 0);
    checkVal("rst_sel2",   fwdSel2, 0);
    checkVal("rst_count",  stallCount, 0);
    checkVal("rst_countS", countSat, 0);
    repeat (2) @(negedge clk);
    issueValid = 1'b0; useRs1 = 1'b0; useRs2 = 1'b0;
    resetIn = 1'b0;

    // ALU back-to-back
    setIn(1, 5'd5, 1, 0, 5'd0, 5'd0, 0, 0, 0);
    checkVal("alu_acc0", issueAccept, 1);
    setIn(1, 5'd6, 1, 0, 5'd5, 5'd0, 1, 0, 0);
    checkVal("alu_stall", stall, 0);
    checkVal("alu_sel1",  fwdSel1, 1);
    checkVal("alu_acc1",  issueAccept, 1);
    idle(PIPE_DEPTH);

    // Forward distance 2, 3, then out of the window
    setIn(1, 5'd5, 1, 0, 5'd0, 5'd0, 0, 0, 0);
    idle(1);
    setIn(1, 5'd0, 0, 0, 5'd5, 5'd0, 1, 0, 0);
    checkVal("dist2_sel1", fwdSel1, 2);
    setIn(1, 5'd0, 0, 0, 5'd5, 5'd0, 1, 0, 0);
    checkVal("dist3_sel1", fwdSel1, 3);
    setIn(1, 5'd0, 0, 0, 5'd5, 5'd0, 1, 0, 0);
    checkVal("dist4_sel1", fwdSel1, 0);
    idle(PIPE_DEPTH);

    // Load-use on rs2
    setIn(1, 5'd7, 1, 1, 5'd0, 5'd0, 0, 0, 0);
    checkVal("lw_acc", issueAccept, 1);
    setIn(1, 5'd8, 1, 0, 5'd0, 5'd7, 0, 1, 0);
    checkVal("lu_stall",  stall, 1);
    checkVal("lu_acc",    issueAccept, 0);
    checkVal("lu_sel2",   fwdSel2, 1);
    checkVal("lu_count0", stallCount, 0);
    setIn(1, 5'd8, 1, 0, 5'd0, 5'd7, 0, 1, 0);
    checkVal("lu2_stall", stall, 0);
    checkVal("lu2_acc",   issueAccept, 1);
    checkVal("lu2_sel2",  fwdSel2, 2);
    checkVal("lu2_count", stallCount, 1);
    checkVal("lu2_countS", countSat, 1);
    idle(PIPE_DEPTH);

    // Youngest producer wins
    setIn(1, 5'd5, 1, 0, 5'd0, 5'd0, 0, 0, 0);
    setIn(1, 5'd5, 1, 0, 5'd0, 5'd0, 0, 0, 0);
    setIn(1, 5'd0, 0, 0, 5'd5, 5'd0, 1, 0, 0);
    checkVal("young_sel1", fwdSel1, 1);
    idle(PIPE_DEPTH);

    // A load into x0 never creates a forward or stall
    setIn(1, 5'd0, 1, 1, 5'd0, 5'd0, 0, 0, 0);
    setIn(1, 5'd1, 1, 0, 5'd0, 5'd0, 1, 1, 0);
    checkVal("x0_sel1",  fwdSel1, 0);
    checkVal("x0_sel2",  fwdSel2, 0);
    checkVal("x0_stall", stall, 0);
    idle(PIPE_DEPTH);

    // Flush over a load-use; the flushed load to x9 must not land in S1
    setIn(1, 5'd9, 1, 1, 5'd0, 5'd0, 0, 0, 0);
    setIn(1, 5'd9, 1, 1, 5'd9, 5'd0, 1, 0, 1);
    checkVal("fl_stall", stall, 0);
    checkVal("fl_acc",   issueAccept, 0);
    setIn(1, 5'd10, 1, 0, 5'd9, 5'd0, 1, 0, 0);
    checkVal("fl2_stall", stall, 0);
    checkVal("fl2_sel1",  fwdSel1, 2);
    checkVal("fl2_acc",   issueAccept, 1);
    checkVal("fl2_count", stallCount, 1);
    idle(PIPE_DEPTH);

    // Self-dependent load chain: stalls every other cycle, 5 stalls in total
    setIn(1, 5'd3, 1, 1, 5'd3, 5'd0, 1, 0, 0);
    checkVal("sat_stall0", stall, 0);
    for (int i = 1; i < 10; i++) begin
      setIn(1, 5'd3, 1, 1, 5'd3, 5'd0, 1, 0, 0);
      checkVal($sformatf("sat_stall%0d", i), stall, i % 2);
    end
    setIn(1, 5'd3, 1, 1, 5'd3, 5'd0, 1, 0, 0);
    checkVal("sat_stall10", stall, 0);
    checkVal("sat_count",   stallCount, 6);
    checkVal("sat_countS",  countSat, 3);

    // Reset pulsed in the middle of a stall
    setIn(1, 5'd3, 1, 1, 5'd3, 5'd0, 1, 0, 0);
    checkVal("mid_stall", stall, 1);
    resetIn = 1'b1;
    #1;
    checkVal("mr_stall",  stall, 0);
    checkVal("mr_acc",    issueAccept, 0);
    checkVal("mr_sel1",   fwdSel1, 0);
    checkVal("mr_sel2",   fwdSel2, 0);
    checkVal("mr_count",  stallCount, 0);
    checkVal("mr_countS", countSat, 0);
    @(negedge clk);
    resetIn = 1'b0;
    #1;
    checkVal("pr_stall", stall, 0);
    checkVal("pr_acc",   issueAccept, 1);
    checkVal("pr_sel1",  fwdSel1, 0);
    checkVal("pr_accS",  acceptSat, 1);
    checkVal("pr_sel1S", sel1Sat, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter REG_ADDR_W, default 5, meaning the register-address width.
REQ-002 The block SHALL have parameter PIPE_DEPTH, default 3, meaning the number of tracked stages after issue (S1 = EX ... S[PIPE_DEPTH] = WB).
REQ-003 The block SHALL have parameter LOAD_STAGE, default 2, meaning the first stage at which load data can be forwarded (1 <= LOAD_STAGE <= PIPE_DEPTH).
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning the stall-counter width.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-006 Ports SHALL be:
- clk  in  1  rising-edge clock
- resetIn  in  1  asynchronous active-high reset
- issueValid  in  1  decoded instruction presented
- issueRd  in  REG_ADDR_W  destination register
- issueWe  in  1  instruction writes issueRd
- issueIsLoad  in  1  instruction is a load
- rs1, rs2  in  REG_ADDR_W each  source registers
- useRs1, useRs2  in  1 each  source actually read
- flushIn  in  1  kill the presented instruction
- stall  out  1  presented instruction held this cycle
- issueAccept  out  1  presented instruction enters S1 at next edge
- fwdSel1, fwdSel2  out  clog2(PIPE_DEPTH+1) each  0 = register file, k = forward from stage Sk
- stallCount  out  CNT_W  saturating count of stall cycles

Function
REQ-007 Each stage Sk SHALL hold {valid, rd, we, isLoad}.
REQ-008 On every rising edge not in reset, S[k+1] SHALL take S[k] for k = 1..PIPE_DEPTH-1; S[PIPE_DEPTH] contents SHALL be discarded.
REQ-009 S1 SHALL load {1, issueRd, issueWe, issueIsLoad} when issueAccept = 1; otherwise S1 SHALL load a bubble (valid = 0).
REQ-010 A source SHALL match stage Sk when useRsN = 1, Sk.valid = 1, Sk.we = 1, Sk.rd = rsN, and rsN != 0.
REQ-011 fwdSelN SHALL equal the lowest k that matches, or 0 if none matches; youngest-wins under multiple matches.
REQ-012 A load hazard SHALL exist when the youngest match for either source has isLoad = 1 and k < LOAD_STAGE.
REQ-013 stall SHALL equal issueValid AND load hazard AND NOT flushIn, combinationally.
REQ-014 issueAccept SHALL equal issueValid AND NOT stall AND NOT flushIn.
REQ-015 A stalled instruction inserts a bubble in S1; the hazard clears once the producing load reaches LOAD_STAGE.
REQ-016 With LOAD_STAGE = 2, a dependent instruction immediately after a load SHALL stall exactly 1 cycle.
REQ-017 flushIn SHALL take priority over stall: stall = 0, issueAccept = 0, bubble into S1; existing S1..S[PIPE_DEPTH] SHALL continue to shift unaffected.
REQ-018 Register 0 SHALL never produce a match, a forward, or a stall.
REQ-019 stallCount SHALL increment by 1 on each edge where stall = 1, and SHALL hold at 2^CNT_W - 1 without wrapping.
REQ-020 Outputs fwdSel1/fwdSel2 SHALL be valid whenever issueValid = 1, independent of stall.

Reset
REQ-021 While resetIn = 1, all stage valid bits SHALL clear asynchronously, and stallCount SHALL be 0.
REQ-022 During reset, stall, issueAccept, fwdSel1, and fwdSel2 SHALL be 0.
REQ-023 Reset asserted mid-stall SHALL discard the pending hazard; the first post-reset issue SHALL be accepted with fwdSel = 0.

Verification
REQ-024 The bench SHALL cover the following cases:
- ALU back-to-back: issue add x5; next cycle add x6 with rs1 = x5 -> stall = 0, fwdSel1 = 1.
- Distance forward: add x5, then bubble, then use x5 -> fwdSel1 = 2; at distance PIPE_DEPTH+1 -> fwdSel1 = 0.
- Load-use: lw x7, then add with rs2 = x7 -> stall = 1 for 1 cycle, stallCount = 1, then accepted with fwdSel2 = 2.
- Youngest wins and x0: add x5; add x5; use x5 -> fwdSel1 = 1. Separately, writes to x0 with rs1 = 0 -> fwdSel1 = 0, stall = 0.
- Flush during hazard: load-use condition plus flushIn = 1 -> stall = 0, issueAccept = 0, S1 bubble, stallCount unchanged.
- Saturation/reset: with CNT_W = 2, hold a hazard for 5 cycles -> stallCount = 3. Pulse resetIn mid-stall -> stallCount = 0, all fwdSel = 0.
